x_decode_stage: RTL and testbench
=================================

Name: x_decode_stage

Overview:
- Pipeline stage between instruction fetch and the scalar/vector execute front end.
- Accepts fetched {instr, pc} over valid/ready, classifies the immediate format, and presents instr[31:7] plus a 3-bit immediate-select code that feeds the immediate generator downstream.
- Registered output with a 1-entry skid buffer gives full throughput under backpressure. Supports pipeline flush.

Parameters:
- PC_W, 32, width of the program counter.
- NOP_INSTR, 32'h0000_0013, instruction value held on out_instr at reset and when the stage is empty.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept.
- in_instr  in  32  fetched instruction word.
- in_pc  in  PC_W  PC of in_instr.
- flush  in  1  discard all held and incoming instructions.
- out_valid  out  1  decoded instruction available.
- out_ready  in  1  downstream accepts.
- out_instr  out  32  instruction word; bits [31:7] drive the immediate generator.
- out_pc  out  PC_W  PC of out_instr.
- out_imm_sel  out  3  immediate format code.
- out_illegal  out  1  instruction not decodable.

Behaviour:
- Immediate select codes:
  - 000 I, 001 S, 010 B, 011 U, 100 J.
  - 101 shift-amount: zero-extended instr[24:20].
  - 111 none (the generator outputs zero).
- Opcode (instr[6:0]) to select mapping:
  - LOAD 0000011, JALR 1100111, SYSTEM 1110011 -> 000.
  - OP-IMM 0010011 -> 101 if funct3 is 001 or 101, else 000.
  - STORE 0100011 -> 001.
  - BRANCH 1100011 -> 010.
  - LUI 0110111, AUIPC 0010111 -> 011.
  - JAL 1101111 -> 100.
  - OP 0110011, OP-V 1010111, LOAD-FP 0000111, STORE-FP 0100111, MISC-MEM 0001111 -> 111.
- Illegal instructions:
  - Any other opcode, or instr[1:0] != 2'b11: out_illegal=1, out_imm_sel=111.
  - Illegal instructions still flow through the handshake like any other.
- Decode is combinational on the input; its result is registered with instr/pc.
- Latency and throughput:
  - 1 cycle from input handshake to out_valid.
  - 1 instruction/cycle when out_ready is held high.
- Storage: output register (OR) plus skid register (SK).
- in_ready = !sk_valid && !rst. It is driven from a register only, with no combinational path from out_ready.
- On an input handshake:
  - If OR is empty, or OR is being consumed this cycle, the instruction loads OR.
  - Otherwise it loads SK.
- On an output handshake with SK valid, SK moves to OR in the same cycle. In-order delivery is mandatory.
- Simultaneous input and output handshakes with SK empty: OR is replaced and out_valid stays 1.
- flush:
  - Highest priority. Next cycle out_valid=0 and sk_valid=0.
  - The input presented in the flush cycle is dropped even if in_ready=1.
  - out_ready in the flush cycle is ignored.
- Empty stage:
  - out_instr=NOP_INSTR, out_imm_sel=000, out_illegal=0.
  - out_pc holds its last value.
  - The NOP decodes harmlessly if it is sampled.
- Reset values (synchronous):
  - out_valid=0, sk_valid=0.
  - out_instr=NOP_INSTR, out_pc=0, out_imm_sel=000, out_illegal=0.
  - in_ready=0 while rst is high and 1 in the first cycle after.
- Reset mid-operation discards OR and SK contents; no handshake completes in a reset cycle.
- out_* are stable while out_valid=1 and out_ready=0. Verification checks this.

Decomposition:
- Shared package holds:
  - immediate-select localparams (IMM_I..IMM_SHAMT, IMM_NONE);
  - RV opcode localparams, including OP-V, LOAD-FP and STORE-FP;
  - NOP encoding.
  - The immediate generator uses the same select constants.
- One sub-module, x_imm_sel_dec: purely combinational, instr[31:0] -> {imm_sel, illegal}.
- The stage wraps it with OR/SK control.

Test Plan:
- Decode sweep, out_ready=1:
  - 0x00500093 -> 000, illegal 0.
  - 0x4050D093 (srai) -> 101.
  - 0x00112023 -> 001.
  - 0x00000463 -> 010.
  - 0x123450B7 -> 011.
  - 0x0000006F -> 100.
  - 0x00000057 -> 111, illegal 0.
  - Each appears 1 cycle after its input handshake.
- Illegal: 0x00000000 -> out_illegal=1, out_imm_sel=111. 0x0000007B -> out_illegal=1.
- Backpressure:
  - Setup: stream A,B,C back-to-back; out_ready=0 from the cycle A appears.
  - in_ready drops after B is accepted; C waits.
  - Release: out_ready=1 delivers A,B,C in consecutive cycles with matching pc.
  - out_* stay stable while stalled.
- Flush with both OR and SK full and in_valid=1:
  - next cycle out_valid=0 and in_ready=1;
  - the flushed-cycle input never appears at the output.
- Reset asserted with OR and SK full:
  - next cycle out_valid=0, out_instr=0x00000013, in_ready=0;
  - the first post-reset instruction is delivered normally.
- Random valid/ready toggling over 10k instructions: output sequence equals input sequence and the scoreboard's decode matches.

Source files
------------

// File: rtl/x_decode_stage_pkg.sv
// Shared decode constants: immediate-select codes, RV opcodes, NOP.
// Used by the decode stage and the downstream immediate generator.
package x_decode_stage_pkg;

  localparam logic [2:0] IMM_I     = 3'b000;
  localparam logic [2:0] IMM_S     = 3'b001;
  localparam logic [2:0] IMM_B     = 3'b010;
  localparam logic [2:0] IMM_U     = 3'b011;
  localparam logic [2:0] IMM_J     = 3'b100;
  localparam logic [2:0] IMM_SHAMT = 3'b101;
  localparam logic [2:0] IMM_NONE  = 3'b111;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_OP_V     = 7'b1010111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [31:0] NOP_ENC = 32'h0000_0013;

endpackage

// File: rtl/x_imm_sel_dec.sv
// Combinational immediate-format classifier.
// Ports: instr -> imm_sel (3-bit code), illegal.
module x_imm_sel_dec
  import x_decode_stage_pkg::*;
(
  input  logic [31:0] instr,
  output logic [2:0]  imm_sel,
  output logic        illegal
);

  logic [6:0] op;
  logic [2:0] f3;
  logic       is_shift;
  logic       unused;

  assign op       = instr[6:0];
  assign f3       = instr[14:12];
  assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);
  assign unused   = ^{instr[31:15], instr[11:7]};

  // Any opcode listed here has instr[1:0]==2'b11, so compressed
  // encodings fall through to the illegal default.
  always_comb begin
    imm_sel = IMM_NONE;
    illegal = 1'b0;
    unique case (1'b1)
      (op == OPC_LOAD) || (op == OPC_JALR) ||
      (op == OPC_SYSTEM):
        imm_sel = IMM_I;
      (op == OPC_OP_IMM):
        imm_sel = is_shift ? IMM_SHAMT : IMM_I;
      (op == OPC_STORE):
        imm_sel = IMM_S;
      (op == OPC_BRANCH):
        imm_sel = IMM_B;
      (op == OPC_LUI) || (op == OPC_AUIPC):
        imm_sel = IMM_U;
      (op == OPC_JAL):
        imm_sel = IMM_J;
      (op == OPC_OP) || (op == OPC_OP_V) ||
      (op == OPC_LOAD_FP) || (op == OPC_STORE_FP) ||
      (op == OPC_MISC_MEM):
        imm_sel = IMM_NONE;
      default: begin
        imm_sel = IMM_NONE;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/x_decode_stage.sv
// Decode stage: classifies immediate format, registers instr/pc.
// Ports: in_* valid/ready from fetch, out_* valid/ready to execute, flush.
module x_decode_stage
  import x_decode_stage_pkg::*;
#(
  parameter int unsigned PC_W      = 32,
  parameter logic [31:0] NOP_INSTR = NOP_ENC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [PC_W-1:0] out_pc,
  output logic [2:0]      out_imm_sel,
  output logic            out_illegal
);

  logic [2:0]      dec_sel;
  logic            dec_ill;

  logic            or_valid;
  logic            sk_valid;
  logic [31:0]     sk_instr;
  logic [PC_W-1:0] sk_pc;
  logic [2:0]      sk_sel;
  logic            sk_ill;

  logic            in_hs;
  logic            out_hs;

  x_imm_sel_dec u_dec (
    .instr   (in_instr),
    .imm_sel (dec_sel),
    .illegal (dec_ill)
  );

  // Ready depends only on the skid flag, never on out_ready.
  assign in_ready  = !sk_valid && !rst;
  assign in_hs     = in_valid && in_ready && !flush;
  assign out_hs    = or_valid && out_ready && !flush;
  assign out_valid = or_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      or_valid    <= 1'b0;
      sk_valid    <= 1'b0;
      out_instr   <= NOP_INSTR;
      out_pc      <= '0;
      out_imm_sel <= IMM_I;
      out_illegal <= 1'b0;
    end else if (flush) begin
      or_valid    <= 1'b0;
      sk_valid    <= 1'b0;
      out_instr   <= NOP_INSTR;
      out_imm_sel <= IMM_I;
      out_illegal <= 1'b0;
    end else if (out_hs && sk_valid) begin
      // in_ready is low here, so no new input competes.
      out_instr   <= sk_instr;
      out_pc      <= sk_pc;
      out_imm_sel <= sk_sel;
      out_illegal <= sk_ill;
      sk_valid    <= 1'b0;
    end else if (in_hs && (!or_valid || out_hs)) begin
      or_valid    <= 1'b1;
      out_instr   <= in_instr;
      out_pc      <= in_pc;
      out_imm_sel <= dec_sel;
      out_illegal <= dec_ill;
    end else if (in_hs) begin
      sk_valid    <= 1'b1;
      sk_instr    <= in_instr;
      sk_pc       <= in_pc;
      sk_sel      <= dec_sel;
      sk_ill      <= dec_ill;
    end else if (out_hs) begin
      // Drained: show a harmless NOP, keep the last pc.
      or_valid    <= 1'b0;
      out_instr   <= NOP_INSTR;
      out_imm_sel <= IMM_I;
      out_illegal <= 1'b0;
    end
  end

endmodule

// File: tb/tb_x_decode_stage.sv
// Scoreboard bench for x_decode_stage: directed cases plus random traffic.
// Input monitor pushes model results; output monitor pops and compares.
module tb_x_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [2:0]  out_imm_sel;
  logic        out_illegal;

  always #5 clk = ~clk;

  x_decode_stage dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .out_imm_sel (out_imm_sel),
    .out_illegal (out_illegal)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [2:0]  sel;
    logic        ill;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_out  = 0;
  bit   armed  = 0;

  function automatic void chk(string name, logic [67:0] act,
                              logic [67:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endfunction

  // Reference decode straight from the opcode table: {sel, illegal}.
  function automatic logic [3:0] ref_dec(logic [31:0] i);
    logic [2:0] f3;
    f3 = i[14:12];
    case (i[6:0])
      7'h03, 7'h67, 7'h73:        return 4'b000_0;
      7'h13:  return (f3 == 3'd1 || f3 == 3'd5) ? 4'b101_0 : 4'b000_0;
      7'h23:                      return 4'b001_0;
      7'h63:                      return 4'b010_0;
      7'h37, 7'h17:               return 4'b011_0;
      7'h6F:                      return 4'b100_0;
      7'h33, 7'h57, 7'h07,
      7'h27, 7'h0F:               return 4'b111_0;
      default:                    return 4'b111_1;
    endcase
  endfunction

  // Input monitor: a handshake will complete at the coming edge.
  always @(negedge clk) begin
    exp_t e;
    logic [3:0] d;
    if (armed && !rst && !flush && in_valid && in_ready) begin
      d = ref_dec(in_instr);
      e.instr = in_instr;
      e.pc    = in_pc;
      e.sel   = d[3:1];
      e.ill   = d[0];
      sbq.push_back(e);
    end
  end

  // Output monitor: stability, empty-stage value, in-order delivery.
  bit          stall_prev = 0;
  logic [67:0] held;
  always @(negedge clk) begin
    exp_t e;
    if (armed) begin
      if (stall_prev)
        chk("stable", {out_valid, out_instr, out_pc, out_imm_sel},
            {1'b1, held[66:0]});
      if (!out_valid)
        chk("empty_nop", {out_instr, out_imm_sel, out_illegal},
            {32'h13, 3'b000, 1'b0});
      if (rst || flush) begin
        sbq.delete();
        stall_prev = 0;
      end else begin
        if (out_valid && out_ready) begin
          n_out++;
          if (sbq.size() == 0) begin
            chk("unexpected_out", {36'd0, out_instr}, 68'd0);
          end else begin
            e = sbq.pop_front();
            chk("out_data", {out_instr, out_pc, out_imm_sel, out_illegal},
                {e.instr, e.pc, e.sel, e.ill});
          end
        end
        stall_prev = out_valid && !out_ready;
        held = {1'b1, out_instr, out_pc, out_imm_sel};
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_two(logic [31:0] a, logic [31:0] b);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = a;
    in_pc     = 32'h2000;
    step();
    in_instr  = b;
    in_pc     = 32'h2004;
    step();
    chk("fill_full", {out_valid, in_ready}, {1'b1, 1'b0});
  endtask

  logic [31:0] sweep_v [9];
  logic [2:0]  sweep_s [9];
  logic        sweep_i [9];
  logic [6:0]  ops [14];

  initial begin
    int cyc;
    int sent;
    logic [31:0] r;
    logic acc;

    sweep_v = '{32'h00500093, 32'h4050D093, 32'h00112023, 32'h00000463,
                32'h123450B7, 32'h0000006F, 32'h00000057, 32'h00000000,
                32'h0000007B};
    sweep_s = '{3'd0, 3'd5, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7, 3'd7, 3'd7};
    sweep_i = '{0, 0, 0, 0, 0, 0, 0, 1, 1};
    ops = '{7'h03, 7'h67, 7'h73, 7'h13, 7'h23, 7'h63, 7'h37,
            7'h17, 7'h6F, 7'h33, 7'h57, 7'h07, 7'h27, 7'h0F};

    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    flush = 1'b0; out_ready = 1'b0;
    step();
    armed = 1;
    chk("reset_state", {out_valid, out_instr, out_pc, out_imm_sel,
                        out_illegal, in_ready},
        {1'b0, 32'h13, 32'h0, 3'b000, 1'b0, 1'b0});
    step();
    rst = 1'b0;
    #1;
    chk("ready_after_reset", {67'd0, in_ready}, 68'd1);

    // Back-to-back decode sweep, each visible one cycle after acceptance.
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      in_instr = sweep_v[i];
      in_pc    = 32'h1000 + 32'(i * 4);
      step();
      chk("sweep", {out_valid, out_instr, out_imm_sel, out_illegal},
          {1'b1, sweep_v[i], sweep_s[i], sweep_i[i]});
    end
    in_valid = 1'b0;
    step();

    // Backpressure: A, B, C with out_ready low from A onward.
    in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h3000;
    out_ready = 1'b0;
    step();
    in_instr = 32'h00200113; in_pc = 32'h3004;
    step();
    chk("bp_ready_drop", {in_ready, out_instr}, {1'b0, 32'h00100093});
    in_instr = 32'h00300193; in_pc = 32'h3008;
    step();
    chk("bp_stall", {in_ready, out_valid, out_instr},
        {1'b0, 1'b1, 32'h00100093});
    out_ready = 1'b1;
    step();
    chk("bp_b", {out_valid, out_instr, out_pc, in_ready},
        {1'b1, 32'h00200113, 32'h3004, 1'b1});
    step();
    in_valid = 1'b0;
    chk("bp_c", {out_valid, out_instr, out_pc},
        {1'b1, 32'h00300193, 32'h3008});
    step();
    chk("bp_drain", {67'd0, out_valid}, 68'd0);

    // Flush with both registers full and a new input offered.
    fill_two(32'h00400213, 32'h00500293);
    in_instr = 32'hDEAD0013; in_pc = 32'h2008;
    flush = 1'b1; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush", {out_valid, in_ready}, {1'b0, 1'b1});
    step(); step();

    // Reset with both registers full.
    fill_two(32'h00600313, 32'h00700393);
    rst = 1'b1;
    step();
    chk("mid_reset", {out_valid, out_instr, in_ready},
        {1'b0, 32'h13, 1'b0});
    rst = 1'b0; in_valid = 1'b1;
    in_instr = 32'h00800413; in_pc = 32'h4000; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("post_reset", {out_valid, out_instr, out_pc},
        {1'b1, 32'h00800413, 32'h4000});
    step();

    // Random traffic; fetch holds each word until it is accepted.
    sent = 0; cyc = 0;
    r = $urandom();
    in_instr = ($urandom_range(0, 9) == 0) ? r :
               {r[31:7], ops[$urandom_range(0, 13)]};
    in_pc = 32'h8000;
    while (sent < 10000 && cyc < 80000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 199) == 0);
      #1;
      acc = in_valid && in_ready && !flush;
      step();
      cyc++;
      if (acc) begin
        sent++;
        r = $urandom();
        in_instr = ($urandom_range(0, 9) == 0) ? r :
                   {r[31:7], ops[$urandom_range(0, 13)]};
        in_pc = in_pc + 32'd4;
      end
    end
    if (cyc >= 80000)
      chk("random_timeout", {36'd0, 32'(sent)}, 68'd10000);
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    step(); step(); step();
    chk("drain_empty", {36'd0, 32'(sbq.size())}, 68'd0);
    if (n_out < 5000)
      chk("enough_outputs", {36'd0, 32'(n_out)}, 68'd5000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
